// File: rtl/bp_host_io_arbiter.sv
// rtl/bp_host_io_arbiter.sv - round-robin host IO command arbiter with in-order response routing
// Optional per-requester grant counters: define BP_HOST_IO_ARB_GRANT_CNT_EN.
module bp_host_io_arbiter #(
  parameter int num_req_p         = 4,
  parameter int header_width_p    = 128,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p*header_width_p-1:0] req_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_ready_and_o,
  output logic [header_width_p-1:0]           rsp_header_o,
  output logic [data_width_p-1:0]             rsp_data_o,
  output logic [num_req_p-1:0]                rsp_v_o,
  input  logic [num_req_p-1:0]                rsp_ready_and_i,
  output logic [header_width_p-1:0]           mem_cmd_header_o,
  output logic [data_width_p-1:0]             mem_cmd_data_o,
  output logic                                mem_cmd_v_o,
  input  logic                                mem_cmd_ready_and_i,
  input  logic [header_width_p-1:0]           mem_resp_header_i,
  input  logic [data_width_p-1:0]             mem_resp_data_i,
  input  logic                                mem_resp_v_i,
  output logic                                mem_resp_ready_and_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                orphan_resp_o,
  output logic [num_req_p*32-1:0]             grant_cnt_o
);
  localparam int IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int CntW = $clog2(max_outstanding_p + 1);
  localparam int PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic                      buf_v_q, buf_v_d;
  logic [header_width_p-1:0] buf_header_q, buf_header_d;
  logic [data_width_p-1:0]   buf_data_q, buf_data_d;
  logic [IdW-1:0]            buf_id_q, buf_id_d;
  logic [IdW-1:0]            rr_q, rr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IdW-1:0]            fifo_q [max_outstanding_p];
  logic [IdW-1:0]            fifo_d [max_outstanding_p];
  logic                      orphan_q, orphan_d;

  logic                 below_max, nonempty, arb_en, grant_v, cmd_v, cmd_fire, resp_fire;
  logic [IdW-1:0]       grant_id, head_id;
  logic [num_req_p-1:0] grant_oh, rsp_v_oh;

  assign below_max = (cnt_q < CntW'(max_outstanding_p));
  assign nonempty  = (cnt_q != '0);
  assign head_id   = fifo_q[rptr_q];
  assign resp_fire = mem_resp_v_i & nonempty & rsp_ready_and_i[head_id];
  // A buffered command may still issue at the limit when a response frees a slot this cycle.
  assign cmd_v     = buf_v_q & (below_max | resp_fire);
  assign cmd_fire  = cmd_v & mem_cmd_ready_and_i;
  assign arb_en    = (~buf_v_q | cmd_fire) & below_max;

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    grant_oh = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (arb_en && !grant_v && req_v_i[(int'(rr_q) + i) % num_req_p]) begin
        grant_v  = 1'b1;
        grant_id = IdW'((int'(rr_q) + i) % num_req_p);
      end
    end
    if (grant_v) grant_oh[grant_id] = 1'b1;
  end

  always_comb begin
    buf_v_d      = buf_v_q & ~cmd_fire;
    buf_header_d = buf_header_q;
    buf_data_d   = buf_data_q;
    buf_id_d     = buf_id_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    fifo_d       = fifo_q;
    orphan_d     = orphan_q | (mem_resp_v_i & ~nonempty);
    if (grant_v) begin
      buf_v_d      = 1'b1;
      buf_header_d = req_header_i[int'(grant_id)*header_width_p +: header_width_p];
      buf_data_d   = req_data_i[int'(grant_id)*data_width_p +: data_width_p];
      buf_id_d     = grant_id;
      rr_d         = (grant_id == IdW'(num_req_p - 1)) ? '0 : grant_id + IdW'(1);
    end
    if (cmd_fire) begin
      fifo_d[wptr_q] = buf_id_q;
      wptr_d = (wptr_q == PtrW'(max_outstanding_p - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (resp_fire)
      rptr_d = (rptr_q == PtrW'(max_outstanding_p - 1)) ? '0 : rptr_q + PtrW'(1);
    if (cmd_fire && !resp_fire)      cnt_d = cnt_q + CntW'(1);
    else if (!cmd_fire && resp_fire) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buf_v_q      <= 1'b0;
      buf_header_q <= '0;
      buf_data_q   <= '0;
      buf_id_q     <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      orphan_q     <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) fifo_q[i] <= '0;
    end else begin
      buf_v_q      <= buf_v_d;
      buf_header_q <= buf_header_d;
      buf_data_q   <= buf_data_d;
      buf_id_q     <= buf_id_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      orphan_q     <= orphan_d;
      fifo_q       <= fifo_d;
    end
  end

  always_comb begin
    rsp_v_oh = '0;
    rsp_v_oh[head_id] = mem_resp_v_i & nonempty;
  end

  // Combinational paths are gated so every output reads 0 while reset is held.
  assign req_ready_and_o      = reset_n_i ? grant_oh : '0;
  assign rsp_v_o              = reset_n_i ? rsp_v_oh : '0;
  assign rsp_header_o         = reset_n_i ? mem_resp_header_i : '0;
  assign rsp_data_o           = reset_n_i ? mem_resp_data_i : '0;
  assign mem_resp_ready_and_o = reset_n_i & (nonempty ? rsp_ready_and_i[head_id] : 1'b1);
  assign mem_cmd_v_o          = cmd_v;
  assign mem_cmd_header_o     = buf_header_q;
  assign mem_cmd_data_o       = buf_data_q;
  assign outstanding_o        = cnt_q;
  assign orphan_resp_o        = orphan_q;

`ifdef BP_HOST_IO_ARB_GRANT_CNT_EN
  logic [num_req_p-1:0][31:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < num_req_p; i++)
      if (grant_oh[i] && gcnt_q[i] != 32'hFFFF_FFFF) gcnt_d[i] = gcnt_q[i] + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) gcnt_q <= '0;
    else            gcnt_q <= gcnt_d;
  end

  assign grant_cnt_o = gcnt_q;
`else
  assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_host_io_arbiter.sv
// tb/tb_bp_host_io_arbiter.sv - directed self-checking bench for bp_host_io_arbiter
module tb_bp_host_io_arbiter;
  localparam int N = 4, HW = 128, DW = 64, MO = 8;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic [N*HW-1:0] req_header_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_v_i, req_ready_and_o, rsp_v_o, rsp_ready_and_i;
  logic [HW-1:0]   rsp_header_o, mem_cmd_header_o, mem_resp_header_i;
  logic [DW-1:0]   rsp_data_o, mem_cmd_data_o, mem_resp_data_i;
  logic            mem_cmd_v_o, mem_cmd_ready_and_i, mem_resp_v_i, mem_resp_ready_and_o, orphan_resp_o;
  logic [3:0]      outstanding_o;
  logic [N*32-1:0] grant_cnt_o;

  int errors = 0;
  int checks = 0;

  bp_host_io_arbiter #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW), .max_outstanding_p(MO)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_header_i(req_header_i), .req_data_i(req_data_i), .req_v_i(req_v_i),
    .req_ready_and_o(req_ready_and_o),
    .rsp_header_o(rsp_header_o), .rsp_data_o(rsp_data_o), .rsp_v_o(rsp_v_o),
    .rsp_ready_and_i(rsp_ready_and_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_and_o(mem_resp_ready_and_o),
    .outstanding_o(outstanding_o), .orphan_resp_o(orphan_resp_o), .grant_cnt_o(grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [HW-1:0] hdr(input int i);
    return HW'(128'hC0DE_0000) + HW'(i);
  endfunction

  function automatic logic [DW-1:0] dat(input int i);
    return DW'(64'hD000) + DW'(i);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, HW'(req_ready_and_o), '0);
    check({tag, ".rsp_v"}, HW'(rsp_v_o), '0);
    check({tag, ".rsp_hdr"}, rsp_header_o, '0);
    check({tag, ".cmd_v"}, HW'(mem_cmd_v_o), '0);
    check({tag, ".cmd_hdr"}, mem_cmd_header_o, '0);
    check({tag, ".resp_rdy"}, HW'(mem_resp_ready_and_o), '0);
    check({tag, ".outst"}, HW'(outstanding_o), '0);
    check({tag, ".orphan"}, HW'(orphan_resp_o), '0);
    check({tag, ".gcnt"}, HW'(grant_cnt_o), '0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_header_i[i*HW +: HW] = hdr(i);
      req_data_i[i*DW +: DW]   = dat(i);
    end
    reset_n_i = 1'b0;
    req_v_i = '1;
    rsp_ready_and_i = '1;
    mem_cmd_ready_and_i = 1'b1;
    mem_resp_header_i = 128'hBEEF_0001;
    mem_resp_data_i = 64'h5555_0001;
    mem_resp_v_i = 1'b1;
    step();
    step();
    check_all_zero("rst");
    req_v_i = '0;
    mem_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    step();

    // single command from requester 2
    req_v_i = 4'b0100;
    #1 check("t1.grant", HW'(req_ready_and_o), HW'(4'b0100));
    check("t1.cmd_v_pre", HW'(mem_cmd_v_o), '0);
    step();
    req_v_i = '0;
    #1 check("t1.cmd_v", HW'(mem_cmd_v_o), 1);
    check("t1.cmd_hdr", mem_cmd_header_o, hdr(2));
    check("t1.cmd_dat", HW'(mem_cmd_data_o), HW'(dat(2)));
    step();
    check("t1.outst1", HW'(outstanding_o), 1);
    check("t1.cmd_v_off", HW'(mem_cmd_v_o), '0);
    mem_resp_v_i = 1'b1;
    #1 check("t1.rsp_v", HW'(rsp_v_o), HW'(4'b0100));
    check("t1.resp_rdy", HW'(mem_resp_ready_and_o), 1);
    check("t1.rsp_hdr", rsp_header_o, 128'hBEEF_0001);
    check("t1.rsp_dat", HW'(rsp_data_o), HW'(64'h5555_0001));
    step();
    mem_resp_v_i = 1'b0;
    check("t1.outst0", HW'(outstanding_o), '0);

    // pointer back to 0, then everyone requests with a silent host
    reset_n_i = 1'b0;
    #1 reset_n_i = 1'b1;
    step();
    req_v_i = '1;
    for (int g = 0; g < 12; g++) begin
      #1 check($sformatf("t2.grant%0d", g), HW'(req_ready_and_o), (g <= 8) ? HW'(1 << (g % 4)) : '0);
      if (g >= 1) begin
        check($sformatf("t2.cmd_v%0d", g), HW'(mem_cmd_v_o), (g <= 8) ? 1 : 0);
        if (g <= 8) check($sformatf("t2.cmd_hdr%0d", g), mem_cmd_header_o, hdr((g - 1) % 4));
      end
      step();
    end
    check("t3.outst_max", HW'(outstanding_o), HW'(MO));

    // response at the limit lets the buffered command issue in the same cycle
    req_v_i = '0;
    mem_resp_v_i = 1'b1;
    #1 check("t4.cmd_v", HW'(mem_cmd_v_o), 1);
    check("t4.rsp_v0", HW'(rsp_v_o), HW'(4'b0001));
    check("t4.no_grant", HW'(req_ready_and_o), '0);
    step();
    check("t4.outst_hold", HW'(outstanding_o), HW'(MO));
    check("t4.cmd_v_off", HW'(mem_cmd_v_o), '0);
    rsp_ready_and_i = 4'b1101;
    #1 check("t4.backpressure", HW'(mem_resp_ready_and_o), '0);
    rsp_ready_and_i = '1;
    for (int j = 1; j <= 8; j++) begin
      #1 check($sformatf("t4.order%0d", j), HW'(rsp_v_o), HW'(1 << (j % 4)));
      step();
    end
    mem_resp_v_i = 1'b0;
    check("t4.outst_drained", HW'(outstanding_o), '0);

    // orphan response
    mem_resp_v_i = 1'b1;
    #1 check("t5.resp_rdy", HW'(mem_resp_ready_and_o), 1);
    check("t5.rsp_v", HW'(rsp_v_o), '0);
    step();
    mem_resp_v_i = 1'b0;
    check("t5.orphan", HW'(orphan_resp_o), 1);
    step();
    step();
    check("t5.orphan_hold", HW'(orphan_resp_o), 1);
    check("t5.outst", HW'(outstanding_o), '0);

    // 3 outstanding plus a full buffer, then asynchronous reset
    req_v_i = '1;
    for (int k = 0; k < 4; k++) step();
    req_v_i = '0;
    mem_cmd_ready_and_i = 1'b0;
    #1 check("t6.outst3", HW'(outstanding_o), 3);
    check("t6.buf_full", HW'(mem_cmd_v_o), 1);
    #2 reset_n_i = 1'b0;
    req_v_i = '1;
    mem_resp_v_i = 1'b1;
    #1 check_all_zero("t6.rst");
    mem_resp_v_i = 1'b0;
    req_v_i = '0;
    step();
    reset_n_i = 1'b1;
    req_v_i = '1;
    #1 check("t6.first_grant", HW'(req_ready_and_o), HW'(4'b0001));
    check("t6.gcnt", HW'(grant_cnt_o), '0);
    step();
    req_v_i = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_host_io_arbiter.md
Name: bp_host_io_arbiter

Overview:
- Shares the single-beat host IO mem channel between num_req_p requesters, e.g. per-core IO ports in front of the nonsynth host.
- Arbitrates commands round-robin and registers the winner into a one-entry output buffer.
- Records the winner's id in an in-order id FIFO.
- Routes each returning response to the requester at the FIFO head; the host answers commands strictly in order.

Parameters:
- num_req_p, 4, number of requesters (>=2)
- header_width_p, 128, bedrock mem header width in bits
- data_width_p, 64, single-beat payload width in bits
- max_outstanding_p, 8, maximum commands issued but not yet answered; also the id FIFO depth

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock; reset is asynchronous and active-low
- req_header_i  in  num_req_p*header_width_p  per-requester command header
- req_data_i  in  num_req_p*data_width_p  per-requester command data
- req_v_i  in  num_req_p  per-requester command valid
- req_ready_and_o  out  num_req_p  per-requester command accept (one-hot or zero)
- rsp_header_o  out  header_width_p  response header, broadcast to all requesters
- rsp_data_o  out  data_width_p  response data, broadcast to all requesters
- rsp_v_o  out  num_req_p  per-requester response valid (one-hot or zero)
- rsp_ready_and_i  in  num_req_p  per-requester response ready
- mem_cmd_header_o  out  header_width_p  command header to host
- mem_cmd_data_o  out  data_width_p  command data to host
- mem_cmd_v_o  out  1  command valid to host
- mem_cmd_ready_and_i  in  1  host command ready
- mem_resp_header_i  in  header_width_p  host response header
- mem_resp_data_i  in  data_width_p  host response data
- mem_resp_v_i  in  1  host response valid
- mem_resp_ready_and_o  out  1  host response accept
- outstanding_o  out  clog2(max_outstanding_p+1)  current outstanding count
- orphan_resp_o  out  1  sticky: a response arrived with no outstanding command
- grant_cnt_o  out  num_req_p*32  per-requester grant counters (optional feature)

Behaviour:
Reset:
- reset_n_i low clears asynchronously: output buffer valid, id FIFO (empty), outstanding count, round-robin pointer (points at 0), orphan flag, grant counters.
- All outputs read 0 during reset.
- Assertion mid-transaction drops all in-flight state; there is no replay.

Arbitration:
- Arbitration is enabled when all of these hold:
  - the buffer is empty, or it empties this cycle (mem_cmd_v_o & mem_cmd_ready_and_i);
  - outstanding count < max_outstanding_p;
  - the id FIFO is not full.
- When enabled, the first requester with req_v_i set, searching upward from the pointer with wrap, wins.
- req_ready_and_o is one-hot on the winner; the transfer happens the same cycle.
- The pointer advances to winner+1 mod num_req_p only on a grant. An idle cycle leaves it unchanged.
- No grant is made while arbitration is disabled; req_ready_and_o = 0.

Command path:
- On a grant, the header, data and winner id are captured into the buffer.
- mem_cmd_v_o rises the next cycle, so command latency is 1 cycle.
- Buffer contents are held stable until mem_cmd_ready_and_i.
- Back-to-back issue at one command per cycle is possible when the host is always ready.

Accounting:
- The id is pushed into the FIFO and the count increments when the host accepts the command (mem_cmd_v_o & mem_cmd_ready_and_i), not at grant.
- The count decrements on response accept.
- Simultaneous issue and response leave the count unchanged; this is legal at count = max.

Response path:
- The FIFO head selects the destination requester:
  - rsp_v_o[head] = mem_resp_v_i & fifo_nonempty;
  - mem_resp_ready_and_o = rsp_ready_and_i[head] when the FIFO is nonempty.
- Header and data are forwarded combinationally. The FIFO pops on the handshake.
- Response with an empty FIFO:
  - mem_resp_ready_and_o = 1 and the response is dropped;
  - no rsp_v_o is asserted;
  - orphan_resp_o sets and stays set until reset.

Optional Feature:
- BP_HOST_IO_ARB_GRANT_CNT_EN defined:
  - each requester has a 32-bit counter that increments on its grant and saturates at 0xFFFF_FFFF;
  - grant_cnt_o exposes the counters.
- Undefined: counters are not built; grant_cnt_o is tied to 0.

Test Plan:
- Single requester, host always ready: requester 2 issues one command.
  - mem_cmd_v_o rises 1 cycle after req_ready_and_o[2].
  - outstanding_o becomes 1, then 0 after the response.
  - rsp_v_o = 4'b0100.
- All 4 requesters assert req_v_i continuously, host always ready.
  - Grant order is 0,1,2,3,0,1...
  - One grant per cycle, with no requester granted twice before the others.
- max_outstanding_p=8, host never responds, 10 commands offered.
  - Exactly 8 are issued and outstanding_o = 8; then req_ready_and_o stays 0.
  - One response frees exactly one slot.
- At count 8, a response and a pending command land in the same cycle.
  - Count stays at 8 and the new command is accepted.
  - Responses reach requesters in issue order.
- mem_resp_v_i pulses with the FIFO empty.
  - The response is accepted and no rsp_v_o asserts.
  - orphan_resp_o = 1 and holds until reset_n_i falls.
- reset_n_i asserted asynchronously with 3 commands outstanding and the buffer full.
  - All outputs go to 0 immediately.
  - After release, the first grant goes to requester 0.
  - With BP_HOST_IO_ARB_GRANT_CNT_EN defined, the counters read 0.
